// File: rtl/uart_pwm_ctrl_pkg.sv
// Shared types and constants for the UART command decoder / PWM block.
package uart_pwm_pkg;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_CH   = 2'd1,
        S_DUTY = 2'd2,
        S_CSUM = 2'd3
    } state_e;

    localparam logic [7:0] PWM_TOP        = 8'd254;
    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    function automatic logic [7:0] frame_csum(input logic [7:0] hdr,
                                              input logic [7:0] ch,
                                              input logic [7:0] duty);
        return hdr ^ ch ^ duty;
    endfunction

endpackage

// File: rtl/uart_pwm_ctrl_if.sv
// Received-byte bus from the UART receiver into the command decoder.
interface uart_pwm_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/uart_pwm_ctrl_pwm_channel.sv
// One PWM channel: shadow duty written by the decoder, active duty swapped in
// at the period end, and a registered compare output.
module pwm_channel
    import uart_pwm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cnt_i,
    input  logic       wr_i,
    input  logic [7:0] duty_i,
    output logic       pwm_o
);
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] active_q;
    logic       pwm_q;

    // A write landing on the period end must reach active immediately.
    assign shadow_d = wr_i ? duty_i : shadow_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q <= '0;
            active_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            if (cnt_i == PWM_TOP) begin
                active_q <= shadow_d;
            end
            pwm_q <= (cnt_i < active_q);
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/uart_pwm_ctrl.sv
// Framed-command decoder (HEADER, CH, DUTY, CSUM) with inter-byte timeout,
// driving NUM_CH glitch-free PWM channels off a shared 0..254 counter.
module uart_pwm_ctrl
    import uart_pwm_pkg::*;
#(
    parameter int         NUM_CH         = 4,
    parameter logic [7:0] HEADER         = DEFAULT_HEADER,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    uart_pwm_ctrl_if.slave    rx,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              frame_ok,
    output logic              frame_err
);
    localparam int              TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      NUM_CH_B = 8'(NUM_CH);

    state_e          state_q;
    logic [7:0]      ch_q;
    logic [7:0]      duty_q;
    logic [TO_W-1:0] to_cnt_q;
    logic            rx_valid_q;
    logic            frame_ok_q;
    logic            frame_err_q;
    logic [7:0]      cnt_q, cnt_d;

    logic byte_stb;
    logic frame_good;
    logic commit;
    logic timeout;

    assign byte_stb   = rx.rx_valid & ~rx_valid_q;
    assign frame_good = (rx.rx_data == frame_csum(HEADER, ch_q, duty_q)) &&
                        (ch_q < NUM_CH_B);
    assign commit     = byte_stb && (state_q == S_CSUM) && frame_good;
    // A byte edge on the expiry cycle takes precedence over the timeout.
    assign timeout    = (state_q != S_HDR) && !byte_stb && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_HDR;
            ch_q        <= '0;
            duty_q      <= '0;
            to_cnt_q    <= '0;
            rx_valid_q  <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q  <= rx.rx_valid;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;

            if (state_q == S_HDR || byte_stb) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end

            case (state_q)
                S_HDR: begin
                    if (byte_stb && rx.rx_data == HEADER) begin
                        state_q <= S_CH;
                    end
                end
                S_CH: begin
                    if (byte_stb) begin
                        ch_q    <= rx.rx_data;
                        state_q <= S_DUTY;
                    end
                end
                S_DUTY: begin
                    if (byte_stb) begin
                        duty_q  <= rx.rx_data;
                        state_q <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (byte_stb) begin
                        frame_ok_q  <= frame_good;
                        frame_err_q <= ~frame_good;
                        state_q     <= S_HDR;
                    end
                end
                default: state_q <= S_HDR;
            endcase

            if (timeout) begin
                state_q     <= S_HDR;
                frame_err_q <= 1'b1;
                to_cnt_q    <= '0;
            end
        end
    end

    assign cnt_d = (cnt_q == PWM_TOP) ? 8'd0 : cnt_q + 8'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_channel u_ch (
            .clk    (clk),
            .reset  (reset),
            .cnt_i  (cnt_q),
            .wr_i   (commit && (ch_q == 8'(i))),
            .duty_i (duty_q),
            .pwm_o  (pwm_out[i])
        );
    end

    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_pwm_ctrl.sv
// Directed bench for uart_pwm_ctrl: framing, checksum/channel rejection,
// timeout, period-boundary duty commit and mid-frame reset.
module tb_uart_pwm_ctrl;
    localparam int NUM_CH  = 4;
    localparam int TIMEOUT = 1024;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] pwm_out;
    logic              frame_ok;
    logic              frame_err;

    uart_pwm_ctrl_if rx_if ();

    uart_pwm_ctrl #(
        .NUM_CH         (NUM_CH),
        .HEADER         (8'hA5),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx_if),
        .pwm_out   (pwm_out),
        .frame_ok  (frame_ok),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ok_seen  = 0;
    int err_seen = 0;

    always @(negedge clk) begin
        if (frame_ok === 1'b1)  ok_seen++;
        if (frame_err === 1'b1) err_seen++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        rx_if.rx_data  = b;
        rx_if.rx_valid = 1'b1;
        repeat (hold) tick();
        rx_if.rx_valid = 1'b0;
        tick();
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] d,
                              input logic [7:0] s, input int hold);
        send_byte(8'hA5, hold);
        send_byte(c, hold);
        send_byte(d, hold);
        send_byte(s, hold);
    endtask

    task automatic settle();
        repeat (260) tick();
    endtask

    task automatic measure(input int ch, input int exp_hi, input string name);
        int hi;
        hi = 0;
        repeat (255) begin
            tick();
            if (pwm_out[ch] === 1'b1) hi++;
        end
        n_checks++;
        if (hi !== exp_hi) begin
            n_fail++;
            $display("FAIL %s: ch%0d high %0d of 255, expected %0d", name, ch, hi, exp_hi);
        end
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        rx_if.rx_data  = 8'h00;
        rx_if.rx_valid = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (pwm_out !== 4'b0000) begin
            n_fail++; $display("FAIL reset_pwm: got %b expected 0000", pwm_out);
        end
        n_checks++;
        if (frame_ok !== 1'b0) begin
            n_fail++; $display("FAIL reset_ok: got %b expected 0", frame_ok);
        end
        n_checks++;
        if (frame_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b expected 0", frame_err);
        end
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (pwm_out !== 4'b0000) begin
            n_fail++; $display("FAIL post_reset_pwm: got %b expected 0000", pwm_out);
        end
    endtask

    task automatic test_valid_frame();
        int ok0, err0;
        ok0 = ok_seen; err0 = err_seen;
        send_frame(8'h01, 8'h80, 8'h24, 1);
        repeat (2) tick();
        n_checks++;
        if (ok_seen - ok0 !== 1) begin
            n_fail++; $display("FAIL valid_ok: pulses %0d expected 1", ok_seen - ok0);
        end
        n_checks++;
        if (err_seen - err0 !== 0) begin
            n_fail++; $display("FAIL valid_err: pulses %0d expected 0", err_seen - err0);
        end
        settle();
        measure(1, 128, "valid_ch1");
        measure(0, 0, "valid_ch0");
        measure(2, 0, "valid_ch2");
        measure(3, 0, "valid_ch3");
    endtask

    task automatic test_bad_csum();
        int ok0, err0;
        ok0 = ok_seen; err0 = err_seen;
        send_frame(8'h00, 8'h40, 8'h00, 1);
        repeat (2) tick();
        n_checks++;
        if (err_seen - err0 !== 1) begin
            n_fail++; $display("FAIL csum_err: pulses %0d expected 1", err_seen - err0);
        end
        n_checks++;
        if (ok_seen - ok0 !== 0) begin
            n_fail++; $display("FAIL csum_ok: pulses %0d expected 0", ok_seen - ok0);
        end
        settle();
        measure(0, 0, "csum_ch0");
    endtask

    task automatic test_bad_channel();
        int ok0, err0;
        ok0 = ok_seen; err0 = err_seen;
        send_frame(8'h07, 8'h10, 8'hB2, 1);
        repeat (2) tick();
        n_checks++;
        if (err_seen - err0 !== 1) begin
            n_fail++; $display("FAIL chan_err: pulses %0d expected 1", err_seen - err0);
        end
        n_checks++;
        if (ok_seen - ok0 !== 0) begin
            n_fail++; $display("FAIL chan_ok: pulses %0d expected 0", ok_seen - ok0);
        end
        settle();
        measure(1, 128, "chan_ch1");
        measure(3, 0, "chan_ch3");
    endtask

    task automatic test_full_and_zero();
        int  ok0;
        bit  found;
        logic prev;
        send_frame(8'h02, 8'hFF, 8'h58, 1);
        settle();
        measure(2, 255, "full_ch2");

        // Park in S_CSUM, then align the CSUM edge with cnt==254 using ch1's rising edge.
        send_byte(8'hA5, 1);
        send_byte(8'h02, 1);
        send_byte(8'h00, 1);
        found = 1'b0;
        prev  = pwm_out[1];
        for (int i = 0; i < 600; i++) begin
            tick();
            if (!prev && pwm_out[1]) begin
                found = 1'b1;
                break;
            end
            prev = pwm_out[1];
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL align_sync: ch1 rising edge found %0d expected 1", found);
        end else begin
            ok0 = ok_seen;
            repeat (253) tick();
            rx_if.rx_data  = 8'hA7;
            rx_if.rx_valid = 1'b1;
            tick();
            rx_if.rx_valid = 1'b0;
            n_checks++;
            if (pwm_out[2] !== 1'b1) begin
                n_fail++; $display("FAIL edge_last_high: ch2 %b expected 1", pwm_out[2]);
            end
            n_checks++;
            if (ok_seen - ok0 !== 1) begin
                n_fail++; $display("FAIL edge_ok: pulses %0d expected 1", ok_seen - ok0);
            end
            tick();
            n_checks++;
            if (pwm_out[2] !== 1'b0) begin
                n_fail++; $display("FAIL edge_next_low: ch2 %b expected 0", pwm_out[2]);
            end
            measure(2, 0, "zero_ch2");
        end
    endtask

    task automatic test_timeout();
        int err0, ok0;
        send_byte(8'hA5, 1);
        send_byte(8'h01, 1);
        err0 = err_seen;
        repeat (TIMEOUT - 2) tick();
        n_checks++;
        if (err_seen - err0 !== 0) begin
            n_fail++; $display("FAIL timeout_early: pulses %0d expected 0", err_seen - err0);
        end
        tick();
        n_checks++;
        if (err_seen - err0 !== 1) begin
            n_fail++; $display("FAIL timeout_fire: pulses %0d expected 1", err_seen - err0);
        end
        repeat (2) tick();
        n_checks++;
        if (err_seen - err0 !== 1) begin
            n_fail++; $display("FAIL timeout_width: pulses %0d expected 1", err_seen - err0);
        end
        ok0 = ok_seen;
        send_frame(8'h03, 8'h20, 8'h86, 1);
        repeat (2) tick();
        n_checks++;
        if (ok_seen - ok0 !== 1) begin
            n_fail++; $display("FAIL after_timeout_ok: pulses %0d expected 1", ok_seen - ok0);
        end
        settle();
        measure(3, 32, "after_timeout_ch3");
        measure(1, 128, "after_timeout_ch1");
    endtask

    task automatic test_back_to_back_held();
        int ok0, err0;
        ok0 = ok_seen; err0 = err_seen;
        send_frame(8'h01, 8'h40, 8'hE4, 5);
        repeat (2) tick();
        n_checks++;
        if (ok_seen - ok0 !== 1) begin
            n_fail++; $display("FAIL held_ok: pulses %0d expected 1", ok_seen - ok0);
        end
        n_checks++;
        if (err_seen - err0 !== 0) begin
            n_fail++; $display("FAIL held_err: pulses %0d expected 0", err_seen - err0);
        end
        settle();
        measure(1, 64, "held_ch1");
    endtask

    task automatic test_reset_mid_frame();
        int ok0, err0;
        send_byte(8'hA5, 1);
        send_byte(8'h00, 1);
        send_byte(8'h30, 1);
        reset = 1'b0;
        #2;
        n_checks++;
        if (pwm_out !== 4'b0000) begin
            n_fail++; $display("FAIL midrst_pwm: got %b expected 0000", pwm_out);
        end
        n_checks++;
        if (frame_ok !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++; $display("FAIL midrst_flags: ok %b err %b expected 0 0", frame_ok, frame_err);
        end
        repeat (2) tick();
        reset = 1'b1;
        tick();
        ok0 = ok_seen; err0 = err_seen;
        send_byte(8'h95, 1);
        repeat (2) tick();
        n_checks++;
        if (ok_seen - ok0 !== 0 || err_seen - err0 !== 0) begin
            n_fail++;
            $display("FAIL midrst_stale_csum: ok %0d err %0d expected 0 0", ok_seen - ok0, err_seen - err0);
        end
        send_frame(8'h00, 8'h30, 8'h95, 1);
        repeat (2) tick();
        n_checks++;
        if (ok_seen - ok0 !== 1) begin
            n_fail++; $display("FAIL midrst_ok: pulses %0d expected 1", ok_seen - ok0);
        end
        settle();
        measure(0, 48, "midrst_ch0");
        measure(1, 0, "midrst_ch1");
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_bad_csum();
        test_bad_channel();
        test_full_and_zero();
        test_timeout();
        test_back_to_back_held();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
